// File: rtl/jk_drive_sequencer.sv
// jk_drive_sequencer: replays a target bit pattern MSB-first onto a JK flip-flop.
// Optional JK_SEQ_REPEAT_EN adds repeat_en to loop the pattern without an IDLE gap.
module jk_drive_sequencer #(
    parameter int PATTERN_W = 8,
    parameter int DIV_W     = 4
) (
    input  logic                 clk1,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [PATTERN_W-1:0] in_data,
    output logic                 in_ready,
    input  logic                 q_fb,
    output logic                 j,
    output logic                 k,
    output logic                 bit_tick,
    output logic                 busy,
    output logic                 done,
    output logic                 err
`ifdef JK_SEQ_REPEAT_EN
    ,
    input  logic                 repeat_en
`endif
);

    localparam int CNT_W = $clog2(PATTERN_W);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t               state;
    logic [PATTERN_W-1:0] shreg;
    logic [DIV_W-1:0]     presc;
    logic [CNT_W-1:0]     bcnt;
`ifdef JK_SEQ_REPEAT_EN
    logic [PATTERN_W-1:0] pat;
`endif

    // JK excitation: {j,k} moving q toward t; 11 is never produced
    function automatic logic [1:0] jk_of(input logic t, input logic q);
        jk_of = {t & ~q, ~t & q};
    endfunction

    // Final cycle of each bit-period
    assign bit_tick = busy && (presc == '1);

    // Capture, bit-period timing, shifting and feedback checking
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            j        <= 1'b0;
            k        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            presc    <= '0;
            bcnt     <= '0;
            shreg    <= '0;
`ifdef JK_SEQ_REPEAT_EN
            pat      <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= PLAY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        presc    <= '0;
                        bcnt     <= CNT_W'(PATTERN_W - 1);
                        shreg    <= in_data;
`ifdef JK_SEQ_REPEAT_EN
                        pat      <= in_data;
`endif
                        {j, k}   <= jk_of(in_data[PATTERN_W-1], q_fb);
                    end
                end
                PLAY: begin
                    presc <= presc + 1'b1;
                    if (bit_tick) begin
                        if (q_fb != shreg[PATTERN_W-1])
                            err <= 1'b1;
                        if (bcnt != '0) begin
                            bcnt   <= bcnt - 1'b1;
                            shreg  <= {shreg[PATTERN_W-2:0], 1'b0};
                            {j, k} <= jk_of(shreg[PATTERN_W-2], q_fb);
`ifdef JK_SEQ_REPEAT_EN
                        end else if (repeat_en) begin
                            done   <= 1'b1;
                            bcnt   <= CNT_W'(PATTERN_W - 1);
                            shreg  <= pat;
                            {j, k} <= jk_of(pat[PATTERN_W-1], q_fb);
`endif
                        end else begin
                            state    <= IDLE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                            j        <= 1'b0;
                            k        <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
